// File: rtl/des_pkg.sv
// des_pkg: shared constants for the DES round sequencer.
//   - DES_ROUNDS        : full DES round count
//   - ST_* constants    : sequencer state encoding (IDLE, LOAD, ROUND, DONE)
//   - ENC_SHIFT         : per-round left-rotate amounts of the C/D key halves
//   - DEC_SHIFT         : per-round right-rotate amounts for decryption
//   - key_shift_for()   : table lookup by round number and direction
package des_pkg;

  localparam int DES_ROUNDS = 16;

  // Sequencer state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Packed tables, entry 15 written first (leftmost), entry 0 last.
  // Encrypt rotates left by 1 in rounds 0, 1, 8, 15 and by 2 elsewhere.
  localparam logic [15:0][1:0] ENC_SHIFT = {
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
    2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1
  };

  // Decrypt walks the schedule backwards: PC1 output already equals K16's
  // C/D, so round 0 needs no rotation and the rest mirror the encrypt table.
  localparam logic [15:0][1:0] DEC_SHIFT = {
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
    2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0
  };

  function automatic logic [1:0] key_shift_for(input logic [3:0] idx, input logic decrypt);
    return decrypt ? DEC_SHIFT[idx] : ENC_SHIFT[idx];
  endfunction

endpackage

// File: rtl/des_key_shift_lut.sv
// des_key_shift_lut: combinational key-schedule rotate lookup.
// Ports:
//   active          in   high while the sequencer is running a round
//   round_idx       in   current round number (IDX_W bits)
//   decrypt         in   latched block direction
//   key_shift       out  rotate amount 0..2 for the C/D halves (0 when idle)
//   key_shift_right out  rotate direction, 1 = right (0 when idle)
module des_key_shift_lut
  import des_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             active,
  input  logic [IDX_W-1:0] round_idx,
  input  logic             decrypt,
  output logic [1:0]       key_shift,
  output logic             key_shift_right
);

  logic [3:0] idx4;

  // The shift tables always have 16 entries; reduced-round builds use a
  // narrower index, so widen (or trim) it to the table index width.
  assign idx4 = 4'(round_idx);

  always_comb begin
    key_shift       = 2'd0;
    key_shift_right = 1'b0;
    if (active) begin
      key_shift       = key_shift_for(idx4, decrypt);
      key_shift_right = decrypt;
    end
  end

endmodule

// File: rtl/des_round_sequencer.sv
// des_round_sequencer: control FSM for the iterative DES round datapath.
// Accepts a block request by valid/ready, strobes the datapath load, steps
// NUM_ROUNDS rounds (one per clock) and holds res_valid until taken.
// Optional feature macro: DES_SEQ_ABORT_EN adds an 'abort' input that drops
// an in-flight or completed block and returns to IDLE.
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   req_valid/ready  request handshake; req_decrypt sampled on handshake
//   dp_load          one-cycle datapath load strobe (IP / PC1)
//   dp_round_en      datapath performs a Feistel round this cycle
//   round_idx        current round number
//   key_shift        C/D rotate amount this round
//   key_shift_right  C/D rotate direction (1 = right, decrypt)
//   last_round       final round, datapath skips the L/R swap
//   res_valid/ready  result handshake
//   abort            (DES_SEQ_ABORT_EN only) discard the current block
module des_round_sequencer
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = DES_ROUNDS,
  parameter int IDX_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_decrypt,
  output logic             req_ready,
  output logic             dp_load,
  output logic             dp_round_en,
  output logic [IDX_W-1:0] round_idx,
  output logic [1:0]       key_shift,
  output logic             key_shift_right,
  output logic             last_round,
  output logic             res_valid,
  input  logic             res_ready
`ifdef DES_SEQ_ABORT_EN
  ,
  input  logic             abort
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);

  logic [1:0]       state;
  logic [IDX_W-1:0] count;
  logic             decrypt_q;
  logic             in_round;
  logic             abort_hit;

`ifdef DES_SEQ_ABORT_EN
  // Abort only matters once a block has been accepted.
  assign abort_hit = abort && (state != ST_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // The counter is cleared on every exit from ROUND so it only ever holds a
  // non-zero value while rounds are running.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      decrypt_q <= 1'b0;
    end else if (abort_hit) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            decrypt_q <= req_decrypt;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          count <= '0;
          state <= ST_ROUND;
        end
        ST_ROUND: begin
          if (count == LAST_IDX) begin
            count <= '0;
            state <= ST_DONE;
          end else begin
            count <= count + IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (res_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_round = (state == ST_ROUND);

  // req_ready is held low while rst is asserted even if the state is IDLE.
  assign req_ready   = (state == ST_IDLE) && !rst;
  assign dp_load     = (state == ST_LOAD);
  assign dp_round_en = in_round;
  assign round_idx   = in_round ? count : '0;
  assign last_round  = in_round && (count == LAST_IDX);
  assign res_valid   = (state == ST_DONE);

  des_key_shift_lut #(
    .IDX_W(IDX_W)
  ) u_key_shift_lut (
    .active          (in_round),
    .round_idx       (round_idx),
    .decrypt         (decrypt_q),
    .key_shift       (key_shift),
    .key_shift_right (key_shift_right)
  );

endmodule

// File: tb/tb_des_round_sequencer.sv
// tb_des_round_sequencer: self-checking bench for des_round_sequencer.
// Instantiates a full 16-round sequencer and a 4-round debug build. Expected
// outputs come from a cycle-offset model of the block timeline and the DES
// rotate schedule written from its rule (1 in rounds 0,1,8,15, else 2; 0 in
// decrypt round 0). Abort scenarios compile in with DES_SEQ_ABORT_EN.
module tb_des_round_sequencer;

  localparam int NUM  = 16;
  localparam int NUM4 = 4;

  logic clk;
  logic rst;
  logic req_valid, req_decrypt, res_ready;
  logic req_ready, dp_load, dp_round_en, key_shift_right, last_round, res_valid;
  logic [3:0] round_idx;
  logic [1:0] key_shift;
  logic req_valid4, req_decrypt4, res_ready4;
  logic req_ready4, dp_load4, dp_round_en4, key_shift_right4, last_round4, res_valid4;
  logic [1:0] round_idx4;
  logic [1:0] key_shift4;
`ifdef DES_SEQ_ABORT_EN
  logic abort;
  logic abort4;
`endif

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int hs_cycle = 0;

  logic [11:0] obs16;
  logic [11:0] obs4;

  assign obs16 = {req_ready, dp_load, dp_round_en, round_idx, key_shift,
                  key_shift_right, last_round, res_valid};
  assign obs4  = {req_ready4, dp_load4, dp_round_en4, 2'b00, round_idx4, key_shift4,
                  key_shift_right4, last_round4, res_valid4};

  des_round_sequencer #(.NUM_ROUNDS(NUM), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_decrypt(req_decrypt),
    .req_ready(req_ready), .dp_load(dp_load), .dp_round_en(dp_round_en),
    .round_idx(round_idx), .key_shift(key_shift), .key_shift_right(key_shift_right),
    .last_round(last_round), .res_valid(res_valid), .res_ready(res_ready)
`ifdef DES_SEQ_ABORT_EN
    , .abort(abort)
`endif
  );

  des_round_sequencer #(.NUM_ROUNDS(NUM4), .IDX_W(2)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid4), .req_decrypt(req_decrypt4),
    .req_ready(req_ready4), .dp_load(dp_load4), .dp_round_en(dp_round_en4),
    .round_idx(round_idx4), .key_shift(key_shift4), .key_shift_right(key_shift_right4),
    .last_round(last_round4), .res_valid(res_valid4), .res_ready(res_ready4)
`ifdef DES_SEQ_ABORT_EN
    , .abort(abort4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Reference model ---------------------------------------------------------
  function automatic int exp_shift(input int i, input bit dec);
    if (dec && i == 0) return 0;
    if (i == 0 || i == 1 || i == 8 || i == 15) return 1;
    return 2;
  endfunction

  function automatic logic [11:0] pack(input bit rr, input bit ld, input bit re, input int idx,
                                       input int ks, input bit ksr, input bit lr, input bit rv);
    return {rr, ld, re, 4'(idx), 2'(ks), ksr, lr, rv};
  endfunction

  // Outputs 'off' cycles after the handshake cycle, for off = 1 .. n+1.
  function automatic logic [11:0] model_vec(input int off, input int n, input bit dec);
    int r;
    if (off == 1) return pack(0, 1, 0, 0, 0, 0, 0, 0);
    r = off - 2;
    return pack(0, 0, 1, r, exp_shift(r, dec), dec, r == n - 1, 0);
  endfunction

  function automatic logic [11:0] idle_vec();
    return pack(1, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic logic [11:0] done_vec();
    return pack(0, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  // Scenario tasks ----------------------------------------------------------
  // Runs one block on the 16-round instance from an IDLE cycle, checking every
  // cycle; stalls res_ready for 'stall' DONE cycles; 'chain' keeps a request
  // waiting so the next block is accepted in the first IDLE cycle.
  task automatic exercise_block(input bit dec, input int stall, input bit chain, input bit noise);
    logic [11:0] ev;
    int t0;
    checks++;
    if (obs16 !== idle_vec()) begin
      errors++;
      $display("[TB] FAIL pre_idle: got %h expected %h", obs16, idle_vec());
    end
    req_valid   = 1'b1;
    req_decrypt = dec;
    t0 = cycle;
    hs_cycle = t0;
    for (int off = 1; off <= NUM + 1; off++) begin
      @(posedge clk); #1;
      ev = model_vec(off, NUM, dec);
      checks++;
      if (obs16 !== ev) begin
        errors++;
        $display("[TB] FAIL block_off%0d dec=%0d: got %h expected %h", off, dec, obs16, ev);
      end
      req_valid   = noise ? 1'($urandom) : 1'b0;
      req_decrypt = noise ? 1'($urandom) : ((off >= 5) ? ~dec : dec);
      res_ready   = noise ? 1'($urandom) : 1'b1;
    end
    for (int k = 0; k <= stall; k++) begin
      @(posedge clk); #1;
      checks++;
      if (obs16 !== done_vec()) begin
        errors++;
        $display("[TB] FAIL done_hold k=%0d: got %h expected %h", k, obs16, done_vec());
      end
      if (k == 0) begin
        checks++;
        if (cycle - t0 !== NUM + 2) begin
          errors++;
          $display("[TB] FAIL res_latency: got %0d expected %0d", cycle - t0, NUM + 2);
        end
      end
      res_ready = (k == stall);
      req_valid = (k == stall || !noise) ? chain : 1'($urandom);
    end
    @(posedge clk); #1;
    res_ready = 1'b0;
    if (!chain) req_valid = 1'b0;
    checks++;
    if (obs16 !== idle_vec()) begin
      errors++;
      $display("[TB] FAIL post_idle: got %h expected %h", obs16, idle_vec());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs16 !== 12'h000 || obs4 !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_hold: got %h/%h expected 000/000", obs16, obs4);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (obs16 !== idle_vec() || obs4 !== idle_vec()) begin
      errors++;
      $display("[TB] FAIL reset_release: got %h/%h expected %h", obs16, obs4, idle_vec());
    end
  endtask

  task automatic test_encrypt();
    exercise_block(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_decrypt();
    exercise_block(1'b1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    int first;
    exercise_block(1'b0, 10, 1'b1, 1'b0);
    first = hs_cycle;
    exercise_block(1'b1, 0, 1'b0, 1'b0);
    checks++;
    if (hs_cycle - first !== NUM + 3 + 10) begin
      errors++;
      $display("[TB] FAIL backpressure_interval: got %0d expected %0d", hs_cycle - first, NUM + 13);
    end
  endtask

  task automatic test_back_to_back();
    int first;
    exercise_block(1'b1, 0, 1'b1, 1'b0);
    first = hs_cycle;
    exercise_block(1'b0, 0, 1'b0, 1'b0);
    checks++;
    if (hs_cycle - first !== NUM + 3) begin
      errors++;
      $display("[TB] FAIL issue_interval: got %0d expected %0d", hs_cycle - first, NUM + 3);
    end
  endtask

  task automatic test_random();
    bit chain;
    for (int b = 0; b < 6; b++) begin
      chain = (b == 5) ? 1'b0 : 1'($urandom);
      exercise_block(1'($urandom), int'($urandom_range(0, 4)), chain, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] ev;
    req_valid   = 1'b1;
    req_decrypt = 1'b1;
    for (int off = 1; off <= 9; off++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
    ev = model_vec(9, NUM, 1'b1);
    checks++;
    if (obs16 !== ev) begin
      errors++;
      $display("[TB] FAIL pre_reset_round7: got %h expected %h", obs16, ev);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    for (int c = 0; c < NUM + 4; c++) begin
      checks++;
      if (obs16 !== idle_vec()) begin
        errors++;
        $display("[TB] FAIL reset_discard c=%0d: got %h expected %h", c, obs16, idle_vec());
      end
      @(posedge clk); #1;
    end
    exercise_block(1'b0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_short_rounds();
    logic [11:0] ev;
    int t0;
    for (int d = 0; d < 2; d++) begin
      req_valid4   = 1'b1;
      req_decrypt4 = 1'(d);
      t0 = cycle;
      for (int off = 1; off <= NUM4 + 1; off++) begin
        @(posedge clk); #1;
        req_valid4   = 1'b0;
        req_decrypt4 = 1'($urandom);
        ev = model_vec(off, NUM4, 1'(d));
        checks++;
        if (obs4 !== ev) begin
          errors++;
          $display("[TB] FAIL short_off%0d dec=%0d: got %h expected %h", off, d, obs4, ev);
        end
      end
      @(posedge clk); #1;
      checks++;
      if (obs4 !== done_vec() || cycle - t0 !== NUM4 + 2) begin
        errors++;
        $display("[TB] FAIL short_done: got %h at +%0d expected %h at +%0d",
                 obs4, cycle - t0, done_vec(), NUM4 + 2);
      end
      res_ready4 = 1'b1;
      @(posedge clk); #1;
      res_ready4 = 1'b0;
      checks++;
      if (obs4 !== idle_vec()) begin
        errors++;
        $display("[TB] FAIL short_idle: got %h expected %h", obs4, idle_vec());
      end
    end
  endtask

`ifdef DES_SEQ_ABORT_EN
  task automatic test_abort();
    logic [11:0] ev;
    // Abort while IDLE is ignored; abort while in LOAD drops the block.
    abort       = 1'b1;
    req_valid   = 1'b1;
    req_decrypt = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (obs16 !== model_vec(1, NUM, 1'b0)) begin
      errors++;
      $display("[TB] FAIL abort_idle_ignored: got %h expected %h", obs16, model_vec(1, NUM, 1'b0));
    end
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (obs16 !== idle_vec()) begin
      errors++;
      $display("[TB] FAIL abort_load: got %h expected %h", obs16, idle_vec());
    end
    // Abort at round 3, then no result may appear.
    req_valid = 1'b1;
    for (int off = 1; off <= 5; off++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
    ev = model_vec(5, NUM, 1'b0);
    checks++;
    if (obs16 !== ev) begin
      errors++;
      $display("[TB] FAIL abort_pre_round3: got %h expected %h", obs16, ev);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    for (int c = 0; c < NUM + 3; c++) begin
      checks++;
      if (obs16 !== idle_vec()) begin
        errors++;
        $display("[TB] FAIL abort_round c=%0d: got %h expected %h", c, obs16, idle_vec());
      end
      @(posedge clk); #1;
    end
    // Abort in DONE drops res_valid without a handshake.
    req_valid = 1'b1;
    res_ready = 1'b0;
    for (int off = 1; off <= NUM + 4; off++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
    checks++;
    if (obs16 !== done_vec()) begin
      errors++;
      $display("[TB] FAIL abort_pre_done: got %h expected %h", obs16, done_vec());
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (obs16 !== idle_vec()) begin
      errors++;
      $display("[TB] FAIL abort_done: got %h expected %h", obs16, idle_vec());
    end
  endtask
`endif

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_decrypt  = 1'b0;
    res_ready    = 1'b0;
    req_valid4   = 1'b0;
    req_decrypt4 = 1'b0;
    res_ready4   = 1'b0;
`ifdef DES_SEQ_ABORT_EN
    abort  = 1'b0;
    abort4 = 1'b0;
`endif
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_short_rounds();
`ifdef DES_SEQ_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
